count_seq_monitor: RTL and testbench
====================================

Name: count_seq_monitor

Overview:
- Downstream consumer of the 4-bit free-running up-counter output.
- Samples the counter value every enabled cycle and checks that it advances by exactly +1 modulo 2^CNT_W.
- Counts wrap-arounds (max->0), recognises a counter restart (jump to 0), flags sequence errors and latches a sticky fault after repeated errors.
- Sits between the counter and the status/debug logic; purely observational, with no feedback to the counter.

Parameters:
- CNT_W, 4: width of the monitored count.
- WRAP_W, 8: width of the wrap-around counter (saturating).
- ERR_W, 8: width of the total error counter (saturating).
- ERR_LIMIT, 3: consecutive sequence errors that force the FAULT state; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous soft clear: returns to IDLE and zeroes counters, same effect as rst.
- cnt_en  input  1  count_in is valid this cycle.
- count_in  input  CNT_W  counter value under observation.
- locked  output  1  high in LOCKED state.
- fault  output  1  high in FAULT state; sticky until rst/clr.
- wrap_pulse  output  1  one-cycle pulse on a legal max->0 step.
- restart_pulse  output  1  one-cycle pulse on a detected counter restart.
- err_pulse  output  1  one-cycle pulse on a sequence error.
- wrap_cnt  output  WRAP_W  wrap-arounds seen since clear.
- err_cnt  output  ERR_W  sequence errors seen since clear.

Behaviour:
- Clock/reset: one clock clk. Reset rst is synchronous and active-high; it has priority over everything, clr is next, cnt_en is last.
- Reset/clear values: state=IDLE, prev=0, consec=0, wrap_cnt=0, err_cnt=0, locked=0, fault=0, all pulses 0.
- Outputs are registered. A sample taken at edge N produces its pulses/counter updates visible after edge N, one cycle of latency.
- Pulses are high for exactly one cycle and are 0 on any cycle with cnt_en=0.
- exp = prev+1 mod 2^CNT_W. max = 2^CNT_W-1.
- Every cnt_en sample outside FAULT loads prev<=count_in.
- IDLE: on cnt_en -> ACQ.
- ACQ:
  - count_in==exp -> LOCKED; if prev==max, also wrap_pulse and wrap_cnt++.
  - otherwise stay in ACQ; no error is counted while acquiring.
- LOCKED, with cnt_en:
  - count_in==exp: ok; consec<=0. If prev==max, wrap_pulse and wrap_cnt++.
  - count_in==0 and prev!=max: restart_pulse, consec<=0, -> ACQ, with prev<=0. No error.
  - Any other value: err_pulse, err_cnt++, consec++. When consec+1==ERR_LIMIT -> FAULT; otherwise stay in LOCKED.
- FAULT:
  - Ignores cnt_en; prev and all counters are frozen; no pulses.
  - Exits only via rst or clr.
- cnt_en=0 in any state: hold all state, no pulses.
- Saturation: wrap_cnt and err_cnt stop at all-ones and never wrap.
- consec is 4 bits and only tracks consecutive errors.
- Simultaneous events:
  - clr with cnt_en: clr wins and the sample is discarded.
  - The error that reaches ERR_LIMIT still produces err_pulse and increments err_cnt on the same edge that enters FAULT.
- Reset mid-operation (rst or clr while LOCKED): next state is IDLE, counters are zeroed, and a full re-acquisition is required.

Decomposition:
- Shared include/package holds the state encodings: ST_IDLE=2'd0, ST_ACQ=2'd1, ST_LOCKED=2'd2, ST_FAULT=2'd3.
- The same package holds the default widths CNT_W=4, WRAP_W=8, ERR_W=8.
- One natural sub-module: sat_counter, parameterised width, with inputs clk, rst, clr, inc and output q that saturates at all-ones. It is instantiated twice, for wrap_cnt and err_cnt.
- FSM, prev register and comparators stay in the top module.

Test Plan:
- Reset then clean sequence 0,1,...,15,0,1 with cnt_en=1 -> locked=1 from the 2nd sample; one wrap_pulse after the 15->0 sample; wrap_cnt=1; err_cnt=0.
- Locked at 5, then count_in 6,9,10 -> single err_pulse on 9; err_cnt=1; then 10 is accepted as 9+1, so locked stays 1 and consec returns to 0.
- Locked at 7, then count_in jumps to 0 (upstream reset) -> restart_pulse, locked=0 for one sample, then 1 again after the sample 1; err_cnt unchanged.
- ERR_LIMIT=3, locked at 2, then samples 5,9,13 -> three err_pulses; fault=1 after the third; further samples produce no pulses and err_cnt stays 3.
- 300 clean wrap-arounds -> wrap_cnt saturates at 255.
- In FAULT, assert clr together with cnt_en -> IDLE, fault=0, all counts 0, and that sample is ignored.
- Pulse assertion throughout all scenarios: cnt_en=0 for 4 cycles mid-sequence -> no pulses and state held; the sequence resumes without error.

Source files
------------

// File: rtl/count_seq_monitor_pkg.sv
// ----------------------------------------------------------------------------
// count_seq_monitor_pkg
//
// Shared definitions for the count sequence monitor:
//    state_t          FSM state encoding (IDLE, ACQ, LOCKED, FAULT)
//    DEF_CNT_W        default width of the observed count
//    DEF_WRAP_W       default width of the saturating wrap-around counter
//    DEF_ERR_W        default width of the saturating error counter
//    DEF_ERR_LIMIT    default number of consecutive errors that force FAULT
// ----------------------------------------------------------------------------
package count_seq_monitor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACQ    = 2'd1,
      ST_LOCKED = 2'd2,
      ST_FAULT  = 2'd3
   } state_t;

   localparam int DEF_CNT_W     = 4;
   localparam int DEF_WRAP_W    = 8;
   localparam int DEF_ERR_W     = 8;
   localparam int DEF_ERR_LIMIT = 3;

endpackage

// File: rtl/count_seq_monitor_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//
// Up-counter that sticks at all-ones instead of rolling over.
// Ports:
//    clk   system clock, rising edge
//    rst   synchronous active-high reset, clears the count
//    clr   synchronous soft clear, same effect as rst
//    inc   increment request for this cycle
//    q     current count
// ----------------------------------------------------------------------------
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_count;

   // Clears win over increments; once all-ones is reached further
   // increments are dropped so the count never wraps back to zero.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_count <= '0;
      end else if (inc && (r_count != {WIDTH{1'b1}})) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   assign q = r_count;

endmodule

// File: rtl/count_seq_monitor.sv
// ----------------------------------------------------------------------------
// count_seq_monitor
//
// Watches the output of a free-running up-counter and checks that every
// enabled sample advances by exactly +1 (modulo 2^CNT_W). Counts legal
// wrap-arounds, recognises an upstream restart (jump to zero), counts
// sequence errors and latches a sticky fault after ERR_LIMIT consecutive
// errors. Purely observational.
//
// Ports:
//    clk            system clock, rising edge
//    rst            synchronous active-high reset (highest priority)
//    clr            synchronous soft clear, same effect as rst
//    cnt_en         count_in is valid this cycle
//    count_in       counter value under observation
//    locked         high while in LOCKED
//    fault          high while in FAULT, sticky until rst/clr
//    wrap_pulse     one-cycle pulse on a legal max->0 step
//    restart_pulse  one-cycle pulse on a detected upstream restart
//    err_pulse      one-cycle pulse on a sequence error
//    wrap_cnt       saturating count of wrap-arounds since clear
//    err_cnt        saturating count of sequence errors since clear
// ----------------------------------------------------------------------------
module count_seq_monitor
   import count_seq_monitor_pkg::*;
#(
   parameter int CNT_W     = DEF_CNT_W,
   parameter int WRAP_W    = DEF_WRAP_W,
   parameter int ERR_W     = DEF_ERR_W,
   parameter int ERR_LIMIT = DEF_ERR_LIMIT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              cnt_en,
   input  logic [CNT_W-1:0]  count_in,
   output logic              locked,
   output logic              fault,
   output logic              wrap_pulse,
   output logic              restart_pulse,
   output logic              err_pulse,
   output logic [WRAP_W-1:0] wrap_cnt,
   output logic [ERR_W-1:0]  err_cnt
);

   localparam logic [CNT_W-1:0] MAX_COUNT   = {CNT_W{1'b1}};
   localparam logic [3:0]       LIMIT_COUNT = 4'(ERR_LIMIT);

   state_t           r_state;
   logic [CNT_W-1:0] r_prevCount;
   logic [3:0]       r_consec;
   logic             r_locked;
   logic             r_fault;
   logic             r_wrapPulse;
   logic             r_restartPulse;
   logic             r_errPulse;

   logic [CNT_W-1:0] w_expCount;
   logic             w_match;
   logic             w_prevMax;
   logic             w_isZero;
   logic             w_tracking;
   logic             w_wrapInc;
   logic             w_restartEv;
   logic             w_errInc;
   logic [3:0]       w_consecNext;

   // Sample classification. A zero after max is a legal wrap, so only a
   // zero that does not follow max counts as an upstream restart.
   assign w_expCount   = r_prevCount + CNT_W'(1);
   assign w_match      = (count_in == w_expCount);
   assign w_prevMax    = (r_prevCount == MAX_COUNT);
   assign w_isZero     = (count_in == '0);
   assign w_tracking   = (r_state == ST_ACQ) || (r_state == ST_LOCKED);
   assign w_wrapInc    = cnt_en && w_tracking && w_match && w_prevMax;
   assign w_restartEv  = cnt_en && (r_state == ST_LOCKED) && !w_match
                         && w_isZero && !w_prevMax;
   assign w_errInc     = cnt_en && (r_state == ST_LOCKED) && !w_match
                         && !w_restartEv;
   assign w_consecNext = r_consec + 4'd1;

   // Single FSM block: state, previous sample, consecutive-error tracking
   // and all registered flag/pulse outputs. The pulses mirror the counter
   // increment strobes one edge later so they line up with the counts.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_state        <= ST_IDLE;
         r_prevCount    <= '0;
         r_consec       <= '0;
         r_locked       <= 1'b0;
         r_fault        <= 1'b0;
         r_wrapPulse    <= 1'b0;
         r_restartPulse <= 1'b0;
         r_errPulse     <= 1'b0;
      end else begin
         r_wrapPulse    <= w_wrapInc;
         r_restartPulse <= w_restartEv;
         r_errPulse     <= w_errInc;

         // FAULT freezes the last sample for post-mortem inspection.
         if (cnt_en && (r_state != ST_FAULT)) begin
            r_prevCount <= count_in;
         end

         case (r_state)
            ST_IDLE: begin
               if (cnt_en) begin
                  r_state <= ST_ACQ;
               end
            end
            ST_ACQ: begin
               if (cnt_en && w_match) begin
                  r_state  <= ST_LOCKED;
                  r_locked <= 1'b1;
               end
            end
            ST_LOCKED: begin
               if (cnt_en) begin
                  if (w_match) begin
                     r_consec <= '0;
                  end else if (w_restartEv) begin
                     r_consec <= '0;
                     r_state  <= ST_ACQ;
                     r_locked <= 1'b0;
                  end else begin
                     r_consec <= w_consecNext;
                     if (w_consecNext == LIMIT_COUNT) begin
                        r_state  <= ST_FAULT;
                        r_locked <= 1'b0;
                        r_fault  <= 1'b1;
                     end
                  end
               end
            end
            ST_FAULT: begin
               r_state <= ST_FAULT;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   sat_counter #(
      .WIDTH (WRAP_W)
   ) u_wrapCounter (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (w_wrapInc),
      .q   (wrap_cnt)
   );

   sat_counter #(
      .WIDTH (ERR_W)
   ) u_errCounter (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (w_errInc),
      .q   (err_cnt)
   );

   assign locked        = r_locked;
   assign fault         = r_fault;
   assign wrap_pulse    = r_wrapPulse;
   assign restart_pulse = r_restartPulse;
   assign err_pulse     = r_errPulse;

endmodule

// File: tb/tb_count_seq_monitor.sv
// ----------------------------------------------------------------------------
// tb_count_seq_monitor
//
// Directed self-checking bench for count_seq_monitor with default
// parameters (CNT_W=4, WRAP_W=8, ERR_W=8, ERR_LIMIT=3).
// ----------------------------------------------------------------------------
module tb_count_seq_monitor;

   logic       clk;
   logic       rst;
   logic       clr;
   logic       cnt_en;
   logic [3:0] count_in;
   logic       locked;
   logic       fault;
   logic       wrap_pulse;
   logic       restart_pulse;
   logic       err_pulse;
   logic [7:0] wrap_cnt;
   logic [7:0] err_cnt;

   int total = 0;
   int bad   = 0;

   count_seq_monitor dut (
      .clk           (clk),
      .rst           (rst),
      .clr           (clr),
      .cnt_en        (cnt_en),
      .count_in      (count_in),
      .locked        (locked),
      .fault         (fault),
      .wrap_pulse    (wrap_pulse),
      .restart_pulse (restart_pulse),
      .err_pulse     (err_pulse),
      .wrap_cnt      (wrap_cnt),
      .err_cnt       (err_cnt)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle of inputs, let the edge happen, then settle 1 unit
   // past the edge so outputs are sampled away from it.
   task automatic applyStimulus(input logic en, input logic [3:0] val, input logic c);
      cnt_en   = en;
      count_in = val;
      clr      = c;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic checkState(input string tag, input logic l, input logic f,
                             input logic wp, input logic rp, input logic ep,
                             input logic [7:0] wc, input logic [7:0] ec);
      checkOutput({tag, ".locked"},        {7'd0, locked},        {7'd0, l});
      checkOutput({tag, ".fault"},         {7'd0, fault},         {7'd0, f});
      checkOutput({tag, ".wrap_pulse"},    {7'd0, wrap_pulse},    {7'd0, wp});
      checkOutput({tag, ".restart_pulse"}, {7'd0, restart_pulse}, {7'd0, rp});
      checkOutput({tag, ".err_pulse"},     {7'd0, err_pulse},     {7'd0, ep});
      checkOutput({tag, ".wrap_cnt"},      wrap_cnt,              wc);
      checkOutput({tag, ".err_cnt"},       err_cnt,               ec);
   endtask

   // Linear directed sequence; all expected values are hand-derived.
   initial begin
      rst      = 1'b1;
      clr      = 1'b0;
      cnt_en   = 1'b0;
      count_in = 4'd0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      checkState("reset", 0, 0, 0, 0, 0, 8'd0, 8'd0);
      rst = 1'b0;

      // Clean sequence 0..15,0,1: locks on the 2nd sample, one wrap at 15->0.
      for (int i = 0; i < 18; i++) begin
         applyStimulus(1'b1, 4'(i % 16), 1'b0);
         checkState($sformatf("clean[%0d]", i), (i >= 1), 0, (i == 16), 0, 0,
                    (i >= 16) ? 8'd1 : 8'd0, 8'd0);
      end

      // Advance to 5, then 6 ok, 9 error, 10 accepted as 9+1.
      for (int v = 2; v <= 6; v++) begin
         applyStimulus(1'b1, 4'(v), 1'b0);
         checkState($sformatf("adv[%0d]", v), 1, 0, 0, 0, 0, 8'd1, 8'd0);
      end
      applyStimulus(1'b1, 4'd9, 1'b0);
      checkState("err9", 1, 0, 0, 0, 1, 8'd1, 8'd1);
      applyStimulus(1'b1, 4'd10, 1'b0);
      checkState("ok10", 1, 0, 0, 0, 0, 8'd1, 8'd1);

      // Two more errors: only reaches FAULT if consec was not cleared by 10.
      applyStimulus(1'b1, 4'd13, 1'b0);
      checkState("err13", 1, 0, 0, 0, 1, 8'd1, 8'd2);
      applyStimulus(1'b1, 4'd2, 1'b0);
      checkState("err2", 1, 0, 0, 0, 1, 8'd1, 8'd3);
      applyStimulus(1'b1, 4'd3, 1'b0);
      checkState("ok3", 1, 0, 0, 0, 0, 8'd1, 8'd3);

      // Up to 7, then upstream restart to 0, relock on 1.
      for (int v = 4; v <= 7; v++) begin
         applyStimulus(1'b1, 4'(v), 1'b0);
      end
      checkState("at7", 1, 0, 0, 0, 0, 8'd1, 8'd3);
      applyStimulus(1'b1, 4'd0, 1'b0);
      checkState("restart0", 0, 0, 0, 1, 0, 8'd1, 8'd3);
      applyStimulus(1'b1, 4'd1, 1'b0);
      checkState("relock1", 1, 0, 0, 0, 0, 8'd1, 8'd3);

      // Enable low for 4 cycles with junk on the bus: everything holds.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 4'd9, 1'b0);
         checkState($sformatf("pause[%0d]", i), 1, 0, 0, 0, 0, 8'd1, 8'd3);
      end
      applyStimulus(1'b1, 4'd2, 1'b0);
      checkState("resume2", 1, 0, 0, 0, 0, 8'd1, 8'd3);

      // Fresh reset, lock at 2, then three consecutive errors -> FAULT.
      rst = 1'b1;
      applyStimulus(1'b1, 4'd5, 1'b0);
      checkState("rst2", 0, 0, 0, 0, 0, 8'd0, 8'd0);
      rst = 1'b0;
      applyStimulus(1'b1, 4'd0, 1'b0);
      checkState("f_s0", 0, 0, 0, 0, 0, 8'd0, 8'd0);
      applyStimulus(1'b1, 4'd1, 1'b0);
      applyStimulus(1'b1, 4'd2, 1'b0);
      checkState("f_s2", 1, 0, 0, 0, 0, 8'd0, 8'd0);
      applyStimulus(1'b1, 4'd5, 1'b0);
      checkState("f_e5", 1, 0, 0, 0, 1, 8'd0, 8'd1);
      applyStimulus(1'b1, 4'd9, 1'b0);
      checkState("f_e9", 1, 0, 0, 0, 1, 8'd0, 8'd2);
      applyStimulus(1'b1, 4'd13, 1'b0);
      checkState("f_e13", 0, 1, 0, 0, 1, 8'd0, 8'd3);
      applyStimulus(1'b1, 4'd14, 1'b0);
      checkState("f_hold14", 0, 1, 0, 0, 0, 8'd0, 8'd3);
      applyStimulus(1'b1, 4'd0, 1'b0);
      checkState("f_hold0", 0, 1, 0, 0, 0, 8'd0, 8'd3);
      applyStimulus(1'b1, 4'd7, 1'b0);
      checkState("f_hold7", 0, 1, 0, 0, 0, 8'd0, 8'd3);

      // clr with a sample: sample discarded, so the next 1 only acquires.
      applyStimulus(1'b1, 4'd0, 1'b1);
      checkState("clr", 0, 0, 0, 0, 0, 8'd0, 8'd0);
      applyStimulus(1'b1, 4'd1, 1'b0);
      checkState("clr_s1", 0, 0, 0, 0, 0, 8'd0, 8'd0);
      applyStimulus(1'b1, 4'd2, 1'b0);
      checkState("clr_s2", 1, 0, 0, 0, 0, 8'd0, 8'd0);

      // 300 clean wrap-arounds: wrap_cnt must saturate at 255.
      for (int k = 0; k < 4800; k++) begin
         applyStimulus(1'b1, 4'((3 + k) % 16), 1'b0);
      end
      checkState("sat", 1, 0, 0, 0, 0, 8'd255, 8'd0);
      applyStimulus(1'b1, 4'd3, 1'b0);
      applyStimulus(1'b1, 4'd4, 1'b0);
      checkState("sat_hold", 1, 0, 0, 0, 0, 8'd255, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
